spi_arbiter: RTL and testbench

Shares the single byte-wide ADC-board SPI master between two command requesters: the host command path and the board init sequencer. It also fans the selected transaction out to one of NCS active-low chip selects. Each request is a 1–4 byte transaction that the block sequences byte by byte (CS setup, load, send, receive, CS release). It returns the last received byte to the requester that owns the transaction. Ties between requesters are broken round-robin, and a stalled SPI master is recovered by a timeout.

---
 rtl/spi_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_spi_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one byte-wide SPI master between two requesters and drives NCS active-low chip selects
//
// Each accepted request is a 1-4 byte transaction: CS setup, then load/send/receive per byte,
// then CS release. The last received byte goes back to the requester that owns the transaction.
// Ties are broken round-robin. A cs index >= NCS is answered with an error and causes no bus activity.
//
// Optional macro SPI_ARB_TIMEOUT_EN: when defined, WAIT_RDY/WAIT_RX give up after TIMEOUT
// wait cycles and answer with an error. When undefined, they wait indefinitely.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/ready             request handshake (N = 0, 1); ready is combinational in IDLE
//   reqN_cs/len/data             target chip select, byte count minus 1, transmit bytes ([7:0] first)
//   respN_valid/data/err         one-cycle completion pulse with last received byte or error
//   spitx/spitxdv/spitxready     byte, one-cycle send strobe, master idle
//   spirx/spirxdv                received byte and its one-cycle valid pulse
//   spics_n                      active-low chip selects, at most one low
//   busy                         high whenever the sequencer is not idle
module spi_arbiter #(
    parameter int NCS      = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 2,
    parameter int TIMEOUT  = 1023,
    localparam int CSW     = $clog2(NCS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [CSW-1:0] req0_cs,
    input  logic [1:0]     req0_len,
    input  logic [31:0]    req0_data,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [CSW-1:0] req1_cs,
    input  logic [1:0]     req1_len,
    input  logic [31:0]    req1_data,
    output logic           resp0_valid,
    output logic [7:0]     resp0_data,
    output logic           resp0_err,
    output logic           resp1_valid,
    output logic [7:0]     resp1_data,
    output logic           resp1_err,
    output logic [7:0]     spitx,
    output logic           spitxdv,
    input  logic           spitxready,
    input  logic [7:0]     spirx,
    input  logic           spirxdv,
    output logic [NCS-1:0] spics_n,
    output logic           busy
);
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, WAIT_RDY, WAIT_RX, HOLD, RESP, GAP} state_t;

    localparam logic [CSW:0] NCS_W = (CSW + 1)'(NCS);

    state_t         state_q;
    logic           last_grant_q;
    logic           owner_q;
    logic [1:0]     len_q;
    logic [31:0]    data_q;
    logic [1:0]     idx_q;
    logic [7:0]     rx_last_q;
    logic [7:0]     cnt_q;
    logic [7:0]     spitx_q;
    logic           spitxdv_q;
    logic [NCS-1:0] spics_n_q;
    logic [1:0]     resp_valid_q;
    logic [7:0]     resp_data_q;
    logic           resp_err_q;

    logic           idle;
    logic           grant1;
    logic           bad;
    logic           to_hit;
    logic [CSW-1:0] sel_cs;
    logic [1:0]     sel_len;
    logic [31:0]    sel_data;

    assign idle       = state_q == IDLE;
    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
    assign req0_ready = idle && req0_valid && !grant1;
    assign req1_ready = idle && grant1;
    assign sel_cs     = grant1 ? req1_cs : req0_cs;
    assign sel_len    = grant1 ? req1_len : req0_len;
    assign sel_data   = grant1 ? req1_data : req0_data;
    assign bad        = {1'b0, sel_cs} >= NCS_W;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wcnt_q;
    assign to_hit = wcnt_q == WW'(TIMEOUT);
    // Restarts in LOAD (entry to WAIT_RDY) and on the strobe (entry to WAIT_RX).
    always_ff @(posedge clk)
        if (rst || state_q == LOAD || (state_q == WAIT_RDY && spitxready)) wcnt_q <= '0;
        else if (state_q == WAIT_RDY || state_q == WAIT_RX) wcnt_q <= wcnt_q + 1'b1;
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            len_q        <= '0;
            data_q       <= '0;
            idx_q        <= '0;
            rx_last_q    <= '0;
            cnt_q        <= '0;
            spitx_q      <= '0;
            spitxdv_q    <= 1'b0;
            spics_n_q    <= '1;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 2'b00;
            case (state_q)
                IDLE: if (req0_ready || req1_ready) begin
                    owner_q <= grant1;
                    len_q   <= sel_len;
                    data_q  <= sel_data;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= bad ? RESP : SETUP;
                    if (bad) begin
                        resp_valid_q <= {grant1, !grant1};
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                    end else begin
                        spics_n_q <= ~(NCS'(1) << sel_cs);
                    end
                end
                SETUP: begin
                    state_q <= cnt_q == 8'(CS_SETUP - 1) ? LOAD : SETUP;
                    cnt_q   <= cnt_q + 8'd1;
                end
                LOAD: begin
                    spitx_q <= data_q[{idx_q, 3'b000} +: 8];
                    state_q <= WAIT_RDY;
                end
                WAIT_RDY: if (to_hit) begin
                    spics_n_q    <= '1;
                    state_q      <= RESP;
                    resp_valid_q <= {owner_q, !owner_q};
                    resp_data_q  <= '0;
                    resp_err_q   <= 1'b1;
                end else if (spitxready) begin
                    spitxdv_q <= 1'b1;
                    state_q   <= WAIT_RX;
                end
                WAIT_RX: begin
                    spitxdv_q <= 1'b0;
                    if (to_hit) begin
                        spics_n_q    <= '1;
                        state_q      <= RESP;
                        resp_valid_q <= {owner_q, !owner_q};
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                    // A receive pulse coinciding with the strobe cycle is not taken.
                    end else if (spirxdv && !spitxdv_q) begin
                        rx_last_q <= spirx;
                        idx_q     <= idx_q + 2'd1;
                        state_q   <= idx_q == len_q ? HOLD : LOAD;
                    end
                end
                HOLD: begin
                    spics_n_q    <= '1;
                    state_q      <= RESP;
                    resp_valid_q <= {owner_q, !owner_q};
                    resp_data_q  <= rx_last_q;
                    resp_err_q   <= 1'b0;
                end
                RESP: begin
                    last_grant_q <= owner_q;
                    cnt_q        <= '0;
                    state_q      <= CS_GAP == 0 ? IDLE : GAP;
                end
                GAP: begin
                    state_q <= cnt_q == 8'(CS_GAP - 1) ? IDLE : GAP;
                    cnt_q   <= cnt_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spitx       = spitx_q;
    assign spitxdv     = spitxdv_q;
    assign spics_n     = spics_n_q;
    assign busy        = !idle;
    assign resp0_valid = resp_valid_q[0];
    assign resp1_valid = resp_valid_q[1];
    assign resp0_data  = resp_valid_q[0] ? resp_data_q : '0;
    assign resp1_data  = resp_valid_q[1] ? resp_data_q : '0;
    assign resp0_err   = resp_valid_q[0] && resp_err_q;
    assign resp1_err   = resp_valid_q[1] && resp_err_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized self-checking bench for spi_arbiter with a behavioural SPI master model
module tb_spi_arbiter;
    localparam int NCS = 3, CS_SETUP = 2, CS_GAP = 2, TIMEOUT = 15;

    logic        clk = 0, rst = 1;
    logic        req0_valid = 0, req1_valid = 0;
    logic [1:0]  req0_cs = 0, req1_cs = 0, req0_len = 0, req1_len = 0;
    logic [31:0] req0_data = 0, req1_data = 0;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid, resp0_err, resp1_err;
    logic [7:0]  resp0_data, resp1_data, spitx;
    logic        spitxdv, busy, spitxready;
    logic        stall = 0;
    logic [7:0]  spirx = 0;
    logic        spirxdv = 0;
    logic [2:0]  spics_n;

    int vectors = 0, miscompares = 0;

    assign spitxready = !stall;
    always #5 clk = ~clk;

    spi_arbiter #(.NCS(NCS), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cs(req0_cs), .req0_len(req0_len), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cs(req1_cs), .req1_len(req1_len), .req1_data(req1_data),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_err(resp1_err),
        .spitx(spitx), .spitxdv(spitxdv), .spitxready(spitxready), .spirx(spirx), .spirxdv(spirxdv),
        .spics_n(spics_n), .busy(busy)
    );

    int         cyc = 0, hs_cyc = 0, first_tx_cyc = -1, resp_cyc = 0, overlap = 0, cs_low = 0, pend = 0;
    logic [7:0] rx_pending;
    logic [7:0] tx_log[$], rx_log[$];
    logic [2:0] cs_log[$];
    int         grant_log[$];
    logic [9:0] resp_log[$];

    function automatic logic [2:0] exp_cs(input int cs);
        return 3'(7 - (1 << cs));
    endfunction

    // Monitor plus SPI master: answers each strobe with a random byte three cycles later.
    always @(negedge clk) begin
        cyc++;
        spirxdv = 0;
        if ($countones(~spics_n) > 1) overlap++;
        if (spics_n != 3'b111) cs_low++;
        if (req0_valid && req0_ready) begin grant_log.push_back(0); hs_cyc = cyc; end
        if (req1_valid && req1_ready) begin grant_log.push_back(1); hs_cyc = cyc; end
        if (resp0_valid) begin resp_log.push_back({1'b0, resp0_err, resp0_data}); resp_cyc = cyc; end
        if (resp1_valid) begin resp_log.push_back({1'b1, resp1_err, resp1_data}); resp_cyc = cyc; end
        if (rst) pend = 0;
        else if (spitxdv) begin
            tx_log.push_back(spitx);
            cs_log.push_back(spics_n);
            if (tx_log.size() == 1) first_tx_cyc = cyc;
            rx_pending = 8'($urandom_range(0, 255));
            pend = 3;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                spirx = rx_pending;
                spirxdv = 1;
                rx_log.push_back(rx_pending);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        @(posedge clk); #1;
        tx_log.delete(); cs_log.delete(); rx_log.delete(); resp_log.delete(); grant_log.delete();
        cs_low = 0;
        first_tx_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic send(input int n, input logic [1:0] cs, input logic [1:0] len, input logic [31:0] data);
        @(posedge clk); #1;
        if (n == 0) begin req0_cs = cs; req0_len = len; req0_data = data; req0_valid = 1; end
        else begin req1_cs = cs; req1_len = len; req1_data = data; req1_valid = 1; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n == 0 ? req0_ready : req1_ready) break;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        req0_data = $urandom; req1_data = $urandom;
        req0_cs = 2'($urandom_range(0, 3)); req1_len = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_resp(output bit got);
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = resp_log.size() > 0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        vectors++; if (spics_n !== 3'b111) begin miscompares++; $display("FAIL reset_cs got %b want 111", spics_n); end
        vectors++; if (spitxdv !== 1'b0 || spitx !== 8'h00) begin miscompares++; $display("FAIL reset_tx got dv=%b tx=%h want 0/00", spitxdv, spitx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if ({resp0_valid, resp1_valid, resp0_data, resp1_data, resp0_err, resp1_err} !== '0) begin
            miscompares++; $display("FAIL reset_resp got %b/%b want 0/0", resp0_valid, resp1_valid); end
    endtask

    task automatic test_single_read();
        bit got;
        logic [31:0] d = 32'h00A58001;
        logic [7:0] last;
        clear_logs();
        send(0, 2'd0, 2'd2, d);
        wait_resp(got);
        last = rx_log.size() > 0 ? rx_log[$] : 8'h00;
        vectors++; if (tx_log.size() != 3) begin miscompares++; $display("FAIL single_count got %0d want 3", tx_log.size()); end
        for (int i = 0; i < tx_log.size() && i < 3; i++) begin
            vectors++; if (tx_log[i] !== 8'(d >> (8 * i))) begin miscompares++; $display("FAIL single_byte%0d got %h want %h", i, tx_log[i], 8'(d >> (8 * i))); end
            vectors++; if (cs_log[i] !== 3'b110) begin miscompares++; $display("FAIL single_cs%0d got %b want 110", i, cs_log[i]); end
        end
        vectors++; if (!got || resp_log[0] !== {2'b00, last}) begin miscompares++; $display("FAIL single_resp got %h want %h", got ? resp_log[0] : 10'h3FF, {2'b00, last}); end
        vectors++; if (first_tx_cyc - hs_cyc < CS_SETUP + 2) begin miscompares++; $display("FAIL single_latency got %0d want >=%0d", first_tx_cyc - hs_cyc, CS_SETUP + 2); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            bit got;
            int n = $urandom_range(0, 1), cs = $urandom_range(0, NCS - 1), len = $urandom_range(0, 3);
            logic [31:0] d = $urandom;
            logic [7:0] last;
            clear_logs();
            send(n, 2'(cs), 2'(len), d);
            wait_resp(got);
            last = rx_log.size() > 0 ? rx_log[$] : 8'h00;
            vectors++; if (tx_log.size() != len + 1) begin miscompares++; $display("FAIL rand%0d_count got %0d want %0d", k, tx_log.size(), len + 1); end
            for (int i = 0; i < tx_log.size() && i <= len; i++) begin
                vectors++; if (tx_log[i] !== 8'(d >> (8 * i)) || cs_log[i] !== exp_cs(cs)) begin
                    miscompares++; $display("FAIL rand%0d_byte%0d got %h/%b want %h/%b", k, i, tx_log[i], cs_log[i], 8'(d >> (8 * i)), exp_cs(cs)); end
            end
            vectors++; if (!got || resp_log[0] !== {1'(n), 1'b0, last}) begin
                miscompares++; $display("FAIL rand%0d_resp got %h want %h", k, got ? resp_log[0] : 10'h3FF, {1'(n), 1'b0, last}); end
        end
    endtask

    task automatic test_lengths();
        bit got;
        logic [31:0] d = 32'h44332211;
        clear_logs();
        send(1, 2'd1, 2'd0, {$urandom_range(0, 255), 8'h11});
        wait_resp(got);
        vectors++; if (tx_log.size() != 1 || tx_log[0] !== 8'h11) begin miscompares++; $display("FAIL len0 got %0d bytes first %h want 1 byte 11", tx_log.size(), tx_log.size() > 0 ? tx_log[0] : 8'h00); end
        vectors++; if (!got || resp_log[0][9:8] !== 2'b10) begin miscompares++; $display("FAIL len0_resp got %b want owner1 err0", got); end
        clear_logs();
        send(0, 2'd2, 2'd3, d);
        wait_resp(got);
        vectors++; if (tx_log.size() != 4) begin miscompares++; $display("FAIL len3_count got %0d want 4", tx_log.size()); end
        for (int i = 0; i < tx_log.size() && i < 4; i++) begin
            vectors++; if (tx_log[i] !== 8'(d >> (8 * i))) begin miscompares++; $display("FAIL len3_byte%0d got %h want %h", i, tx_log[i], 8'(d >> (8 * i))); end
        end
    endtask

    task automatic test_bad_cs();
        bit got;
        clear_logs();
        send(1, 2'd3, 2'd1, $urandom);
        wait_resp(got);
        repeat (4) @(negedge clk);
        vectors++; if (!got || resp_log[0] !== 10'b1_1_00000000) begin miscompares++; $display("FAIL badcs_resp got %h want %h", got ? resp_log[0] : 10'h000, 10'b1_1_00000000); end
        vectors++; if (tx_log.size() != 0) begin miscompares++; $display("FAIL badcs_strobes got %0d want 0", tx_log.size()); end
        vectors++; if (cs_low != 0) begin miscompares++; $display("FAIL badcs_cs got %0d low cycles want 0", cs_low); end
    endtask

    task automatic test_tie();
        int last_rx[3] = '{0, 2, 3};
        int cs_seq[4] = '{1, 2, 2, 1};
        do_reset();
        clear_logs();
        req0_cs = 2'd1; req0_len = 2'd0; req0_data = $urandom;
        req1_cs = 2'd2; req1_len = 2'd1; req1_data = $urandom;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 400 && grant_log.size() < 3; i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 400 && resp_log.size() < 3; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (grant_log.size() <= i || grant_log[i] != i % 2) begin
                miscompares++; $display("FAIL tie_grant%0d got %0d want %0d", i, grant_log.size() > i ? grant_log[i] : -1, i % 2); end
            vectors++; if (resp_log.size() <= i || rx_log.size() <= last_rx[i] || resp_log[i] !== {1'(i % 2), 1'b0, rx_log[last_rx[i]]}) begin
                miscompares++; $display("FAIL tie_resp%0d got %h want owner %0d", i, resp_log.size() > i ? resp_log[i] : 10'h3FF, i % 2); end
        end
        vectors++; if (cs_log.size() != 4) begin miscompares++; $display("FAIL tie_strobes got %0d want 4", cs_log.size()); end
        for (int i = 0; i < cs_log.size() && i < 4; i++) begin
            vectors++; if (cs_log[i] !== exp_cs(cs_seq[i])) begin miscompares++; $display("FAIL tie_cs%0d got %b want %b", i, cs_log[i], exp_cs(cs_seq[i])); end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        clear_logs();
        send(0, 2'd1, 2'd2, $urandom);
        for (int i = 0; i < 200 && tx_log.size() < 2; i++) @(negedge clk);
        vectors++; if (tx_log.size() != 2) begin miscompares++; $display("FAIL rstmid_reach got %0d strobes want 2", tx_log.size()); end
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        vectors++; if (spics_n !== 3'b111 || spitxdv !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_state got cs=%b dv=%b busy=%b want 111/0/0", spics_n, spitxdv, busy); end
        repeat (30) @(negedge clk);
        vectors++; if (resp_log.size() != 0) begin miscompares++; $display("FAIL rstmid_noresp got %0d responses want 0", resp_log.size()); end
        clear_logs();
        send(0, 2'd0, 2'd1, 32'h0000BEEF);
        wait_resp(got);
        vectors++; if (!got || tx_log.size() != 2 || tx_log[0] !== 8'hEF || tx_log[1] !== 8'hBE || resp_log[0] !== {2'b00, rx_log[$]}) begin
            miscompares++; $display("FAIL rstmid_after got resp=%0d strobes=%0d want resp=1 strobes=2", got, tx_log.size()); end
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit got;
        clear_logs();
        stall = 1;
        send(0, 2'd2, 2'd1, $urandom);
        wait_resp(got);
        vectors++; if (!got || resp_log[0] !== 10'b0_1_00000000) begin miscompares++; $display("FAIL timeout_resp got %h want %h", got ? resp_log[0] : 10'h000, 10'b0_1_00000000); end
        vectors++; if (resp_cyc - hs_cyc < CS_SETUP + 2 + 14 || resp_cyc - hs_cyc > CS_SETUP + 2 + 18) begin
            miscompares++; $display("FAIL timeout_latency got %0d want about %0d", resp_cyc - hs_cyc, CS_SETUP + 2 + 16); end
        vectors++; if (spics_n !== 3'b111 || tx_log.size() != 0) begin miscompares++; $display("FAIL timeout_release got cs=%b strobes=%0d want 111/0", spics_n, tx_log.size()); end
        stall = 0;
        clear_logs();
        send(0, 2'd2, 2'd0, 32'h0000005A);
        wait_resp(got);
        vectors++; if (!got || tx_log.size() != 1 || resp_log[0] !== {2'b00, rx_log[$]}) begin
            miscompares++; $display("FAIL timeout_after got resp=%0d strobes=%0d want 1/1", got, tx_log.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_random();
        test_lengths();
        test_bad_cs();
        test_tie();
        test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        vectors++; if (overlap != 0) begin miscompares++; $display("FAIL cs_overlap got %0d cycles want 0", overlap); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
